// File: rtl/view_pkg.sv
// view_pkg: shared view codes, FSM state encoding and default parameter
// values for the view sequencer and its button debouncers.
package view_pkg;

   // View codes carried on the view output and used to pick a sample stream
   localparam logic [1:0] VIEW_UPSAMPLED = 2'd0;
   localparam logic [1:0] VIEW_SHAPED    = 2'd1;
   localparam logic [1:0] VIEW_FILTERED  = 2'd2;
   localparam logic [1:0] VIEW_MODULATOR = 2'd3;

   // Sequencer FSM: either showing a view or blanking the output
   typedef enum logic [0:0] {
      ST_SHOW  = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   // Default parameter values
   localparam int DEBOUNCE_CYCLES_DEF = 50000;
   localparam int BLANK_CYCLES_DEF    = 256;
   localparam int DATA_W_DEF          = 12;
   localparam int AUTO_PERIOD_DEF     = 50000000;

   // Next view in the auto-advance rotation; 3 wraps back to 0
   function automatic logic [1:0] next_view(input logic [1:0] v);
      return v + 2'd1;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchronizer, stability counter and a one-cycle
// press pulse on each accepted 0->1 change of one raw push-button.
module button_debounce
   import view_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_0;
   logic             sync_1;
   logic             level;
   logic [CNT_W-1:0] stable_cnt;
   logic             accept;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_0 <= 1'b0;
         sync_1 <= 1'b0;
      end else begin
         sync_0 <= button;
         sync_1 <= sync_0;
      end
   end

   // The last of DEBOUNCE_CYCLES consecutive samples that differ from level
   assign accept = (sync_1 != level) && (stable_cnt == CNT_LAST);

   // Count disagreeing samples; any agreeing sample restarts the count
   always_ff @(posedge clock) begin
      if (!reset) begin
         stable_cnt <= '0;
         level      <= 1'b0;
         press      <= 1'b0;
      end else begin
         press <= accept && sync_1;
         if (sync_1 == level) begin
            stable_cnt <= '0;
         end else if (accept) begin
            stable_cnt <= '0;
            level      <= sync_1;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/view_sequencer.sv
// view_sequencer: selects one of four sample streams for display, switching
// views on debounced button presses and blanking the output for BLANK_CYCLES
// cycles around every change. Define VIEW_AUTO_CYCLE_EN to add an idle timer
// that auto-advances to the next view after AUTO_PERIOD quiet cycles.
//
// Streaming: sig_valid qualifies all four sig_n inputs in the same cycle;
// out_valid/out_data follow one cycle later, and out_data holds its last
// value while sig_valid is low. There is no backpressure.
module view_sequencer
   import view_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int BLANK_CYCLES    = BLANK_CYCLES_DEF,
   parameter int DATA_W          = DATA_W_DEF,
   parameter int AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        button,
   input  logic [DATA_W-1:0] sig_0,
   input  logic [DATA_W-1:0] sig_1,
   input  logic [DATA_W-1:0] sig_2,
   input  logic [DATA_W-1:0] sig_3,
   input  logic              sig_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic [1:0]        view,
   output logic              blanking,
   output logic              debug_state,
   output logic [1:0]        debug_pending
);

   localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);

   logic [3:0]         press;
   logic               press_any;
   logic [1:0]         press_view;
   logic               auto_fire;

   state_t             state_q;
   state_t             state_d;
   logic [1:0]         pending_q;
   logic [1:0]         pending_d;
   logic [1:0]         view_q;
   logic [BLANK_W-1:0] blank_cnt;
   logic               load_blank;
   logic               take_view;
   logic [DATA_W-1:0]  sig_sel;

   // One debouncer per button
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_btn (
            .clock (clock),
            .reset (reset),
            .button(button[gi]),
            .press (press[gi])
         );
      end
   endgenerate

   // Fixed priority among simultaneous pulses: lowest index wins
   always_comb begin
      press_any  = |press;
      press_view = VIEW_UPSAMPLED;
      for (int k = 3; k >= 0; k--) begin
         if (press[k]) press_view = 2'(k);
      end
   end

`ifdef VIEW_AUTO_CYCLE_EN
   localparam int IDLE_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_PERIOD - 1);

   logic [IDLE_W-1:0] idle_cnt;

   // A press pulse in the same cycle takes precedence over the timer
   assign auto_fire = (state_q == ST_SHOW) && !press_any && (idle_cnt == IDLE_LAST);

   // Idle time spent in SHOW; any press pulse or blanking restarts it
   always_ff @(posedge clock) begin
      if (!reset || (state_q == ST_BLANK) || press_any || auto_fire) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end
`else
   // Auto-advance is not built; AUTO_PERIOD is positive so this never fires
   assign auto_fire = (AUTO_PERIOD < 0);
`endif

   // FSM state register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_SHOW;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SHOW: begin
            if ((press_any && (press_view != view_q)) || auto_fire) state_d = ST_BLANK;
         end
         ST_BLANK: begin
            if (!press_any && (blank_cnt == '0)) state_d = ST_SHOW;
         end
         default: state_d = ST_SHOW;
      endcase
   end

   // FSM outputs: counter load, pending update, view commit
   always_comb begin
      load_blank = 1'b0;
      take_view  = 1'b0;
      pending_d  = pending_q;
      case (state_q)
         ST_SHOW: begin
            if (press_any && (press_view != view_q)) begin
               load_blank = 1'b1;
               pending_d  = press_view;
            end else if (auto_fire) begin
               load_blank = 1'b1;
               pending_d  = next_view(view_q);
            end
         end
         ST_BLANK: begin
            // Latest press wins, even one naming the view already shown
            if (press_any) begin
               load_blank = 1'b1;
               pending_d  = press_view;
            end else if (blank_cnt == '0) begin
               take_view = 1'b1;
            end
         end
         default: begin
            load_blank = 1'b0;
         end
      endcase
   end

   // Pending view, blank countdown and the displayed view
   always_ff @(posedge clock) begin
      if (!reset) begin
         pending_q <= VIEW_UPSAMPLED;
         blank_cnt <= '0;
         view_q    <= VIEW_UPSAMPLED;
      end else begin
         pending_q <= pending_d;
         if (load_blank) begin
            blank_cnt <= BLANK_LOAD;
         end else if ((state_q == ST_BLANK) && (blank_cnt != '0)) begin
            blank_cnt <= blank_cnt - BLANK_W'(1);
         end
         if (take_view) view_q <= pending_q;
      end
   end

   // Stream belonging to the displayed view
   always_comb begin
      sig_sel = sig_0;
      case (view_q)
         VIEW_UPSAMPLED: sig_sel = sig_0;
         VIEW_SHAPED:    sig_sel = sig_1;
         VIEW_FILTERED:  sig_sel = sig_2;
         VIEW_MODULATOR: sig_sel = sig_3;
         default:        sig_sel = sig_0;
      endcase
   end

   // Output register: one cycle latency, zeros while blanking, hold when idle
   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= sig_valid;
         if (sig_valid) begin
            out_data <= (state_q == ST_BLANK) ? '0 : sig_sel;
         end
      end
   end

   assign view          = view_q;
   assign blanking      = (state_q == ST_BLANK);
   assign debug_state   = state_q;
   assign debug_pending = pending_q;

endmodule

// File: tb/tb_view_sequencer.sv
// tb_view_sequencer: directed scenarios, a small vector table for the output
// path, and a long randomized run compared cycle by cycle with a reference
// model built from the behavioural rules of the view sequencer.
module tb_view_sequencer;

   localparam int DEB    = 4;
   localparam int BLANK  = 8;
   localparam int DW     = 12;
   localparam int AUTO_P = 32;

   localparam logic [DW-1:0] S0 = 12'h123;
   localparam logic [DW-1:0] S1 = 12'h456;
   localparam logic [DW-1:0] S2 = 12'h789;
   localparam logic [DW-1:0] S3 = 12'hABC;

   logic          clock;
   logic          reset;
   logic [3:0]    button;
   logic [DW-1:0] sig_0, sig_1, sig_2, sig_3;
   logic          sig_valid;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic [1:0]    view;
   logic          blanking;
   logic          debug_state;
   logic [1:0]    debug_pending;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 0;

   view_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .BLANK_CYCLES   (BLANK),
      .DATA_W         (DW),
      .AUTO_PERIOD    (AUTO_P)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .button       (button),
      .sig_0        (sig_0),
      .sig_1        (sig_1),
      .sig_2        (sig_2),
      .sig_3        (sig_3),
      .sig_valid    (sig_valid),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .view         (view),
      .blanking     (blanking),
      .debug_state  (debug_state),
      .debug_pending(debug_pending)
   );

   // ---------------- clock ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- comparison helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Button path: a raw level becomes visible two samples later; it is
   // accepted once the last DEB visible samples all disagree with the
   // accepted level, and an accepted rise yields a pulse the next cycle.
   logic          m_sync0 [4];
   logic          m_sync1 [4];
   logic          m_level [4];
   logic          m_press [4];
   logic [15:0]   m_hist  [4];
   int            m_hlen  [4];
   // Sequencer: showing flag, blank cycles still to go, views
   bit            m_showing;
   int            m_left;
   logic [1:0]    m_view;
   logic [1:0]    m_pending;
   logic [DW-1:0] m_out_data;
   logic          m_out_valid;
`ifdef VIEW_AUTO_CYCLE_EN
   int            m_idle;
`endif

   function automatic logic [DW-1:0] pick(input logic [1:0] v);
      case (v)
         2'd0: return sig_0;
         2'd1: return sig_1;
         2'd2: return sig_2;
         default: return sig_3;
      endcase
   endfunction

   task automatic model_step();
      int         win;
      bit         old_show;
      logic [1:0] old_view;
      logic       s;
      bit         all_diff;
      if (!reset) begin
         for (int b = 0; b < 4; b++) begin
            m_sync0[b] = 0; m_sync1[b] = 0; m_level[b] = 0; m_press[b] = 0;
            m_hist[b] = '0; m_hlen[b] = 0;
         end
         m_showing = 1; m_left = 0; m_view = 0; m_pending = 0;
         m_out_data = '0; m_out_valid = 0;
`ifdef VIEW_AUTO_CYCLE_EN
         m_idle = 0;
`endif
         return;
      end
      win = -1;
      for (int b = 3; b >= 0; b--) if (m_press[b]) win = b;
      old_show = m_showing;
      old_view = m_view;
      if (m_showing) begin
         if (win >= 0) begin
`ifdef VIEW_AUTO_CYCLE_EN
            m_idle = 0;
`endif
            if (2'(win) != m_view) begin
               m_showing = 0; m_pending = 2'(win); m_left = BLANK - 1;
            end
         end else begin
`ifdef VIEW_AUTO_CYCLE_EN
            if (m_idle == AUTO_P - 1) begin
               m_idle = 0;
               m_showing = 0; m_pending = m_view + 2'd1; m_left = BLANK - 1;
            end else begin
               m_idle++;
            end
`endif
         end
      end else begin
`ifdef VIEW_AUTO_CYCLE_EN
         m_idle = 0;
`endif
         if (win >= 0) begin
            m_pending = 2'(win); m_left = BLANK - 1;
         end else if (m_left == 0) begin
            m_showing = 1; m_view = m_pending;
         end else begin
            m_left--;
         end
      end
      m_out_valid = sig_valid;
      if (sig_valid) m_out_data = old_show ? pick(old_view) : '0;
      for (int b = 0; b < 4; b++) begin
         s = m_sync1[b];
         m_sync1[b] = m_sync0[b];
         m_sync0[b] = button[b];
         m_hist[b] = {m_hist[b][14:0], s};
         if (m_hlen[b] < 16) m_hlen[b]++;
         all_diff = (m_hlen[b] >= DEB);
         for (int k = 0; k < DEB; k++) if (m_hist[b][k] == m_level[b]) all_diff = 0;
         m_press[b] = 0;
         if (all_diff) begin
            m_level[b] = ~m_level[b];
            m_press[b] = m_level[b];
            m_hlen[b]  = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   // ---------------- cycle monitor ----------------
   initial forever begin
      @(negedge clock);
      if (mon_en) begin
         check("mon_out_valid", out_valid, m_out_valid);
         check("mon_out_data", out_data, m_out_data);
         check("mon_view", view, m_view);
         check("mon_blanking", blanking, !m_showing);
         check("mon_pending", debug_pending, m_pending);
      end
   end

   // ---------------- driver / watch tasks ----------------
   int w_blank;
   int w_rise;
   bit w_prev;

   task automatic clear_watch();
      w_blank = 0;
      w_rise  = 0;
      w_prev  = blanking;
   endtask

   // Step n cycles, tallying blanking cycles and blanking starts; the cycle
   // after a blanking cycle must present zero data
   task automatic watch(input int n);
      repeat (n) begin
         @(negedge clock);
         if (blanking) w_blank++;
         if (blanking && !w_prev) w_rise++;
         if (w_prev) check("blank_data_zero", out_data, 0);
         w_prev = blanking;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) @(negedge clock);
      check("rst_view", view, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_blanking", blanking, 0);
      reset = 1'b1;
   endtask

   task automatic fixed_sigs();
      sig_0 = S0; sig_1 = S1; sig_2 = S2; sig_3 = S3; sig_valid = 1'b1;
   endtask

   // ---------------- output-path vector table ----------------
   typedef struct {
      logic          vld;
      logic [DW-1:0] s0;
      logic          exp_vld;
      logic [DW-1:0] exp_data;
   } vec_t;
   vec_t vecs [8];

   int btn_timer [4];
   int rst_left;

   initial begin
      vecs[0] = '{1'b1, 12'h123, 1'b1, 12'h123};
      vecs[1] = '{1'b0, 12'h456, 1'b0, 12'h123};
      vecs[2] = '{1'b0, 12'h7FF, 1'b0, 12'h123};
      vecs[3] = '{1'b1, 12'h800, 1'b1, 12'h800};
      vecs[4] = '{1'b1, 12'hFFF, 1'b1, 12'hFFF};
      vecs[5] = '{1'b0, 12'h000, 1'b0, 12'hFFF};
      vecs[6] = '{1'b1, 12'h000, 1'b1, 12'h000};
      vecs[7] = '{1'b1, 12'h555, 1'b1, 12'h555};

      // Reset with data already streaming, then one-cycle latency
      reset  = 1'b0;
      button = 4'b0000;
      fixed_sigs();
      @(negedge clock);
      mon_en = 1;
      repeat (2) @(negedge clock);
      check("rst_view", view, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_blanking", blanking, 0);
      reset = 1'b1;
      @(negedge clock);
      check("first_out_data", out_data, 12'h123);
      check("first_out_valid", out_valid, 1);
      check("first_view", view, 0);
      check("first_blanking", blanking, 0);

      // Output path in view 0, including hold while sig_valid is low
      for (int i = 0; i < 8; i++) begin
         sig_valid = vecs[i].vld;
         sig_0     = vecs[i].s0;
         @(negedge clock);
         check("vec_out_valid", out_valid, vecs[i].exp_vld);
         check("vec_out_data", out_data, vecs[i].exp_data);
      end
      fixed_sigs();

      // Held button: one change, eight blank cycles, then the new stream
      do_reset(2);
      clear_watch();
      button = 4'b0100;
      watch(20);
      check("hold_rises", w_rise, 1);
      check("hold_blank_len", w_blank, BLANK);
      check("hold_view", view, 2);
      button = 4'b0000;
      @(negedge clock);
      check("hold_data_sig2", out_data, S2);

      // Bouncing button: 2-cycle glitches are rejected, final hold accepted
      do_reset(2);
      clear_watch();
      for (int r = 0; r < 3; r++) begin
         button = 4'b0010;
         watch(2);
         button = 4'b0000;
         watch(2);
      end
      check("bounce_no_blank", w_blank, 0);
      button = 4'b0010;
      watch(20);
      check("bounce_rises", w_rise, 1);
      check("bounce_blank_len", w_blank, BLANK);
      check("bounce_view", view, 1);
      button = 4'b0000;

      // Simultaneous presses: lowest index wins
      do_reset(2);
      clear_watch();
      button = 4'b1010;
      watch(20);
      check("prio_rises", w_rise, 1);
      check("prio_pending", debug_pending, 1);
      check("prio_view", view, 1);
      button = 4'b0000;

      // Second press during blanking restarts the blank period
      do_reset(2);
      clear_watch();
      button = 4'b0100;
      watch(5);
      button = 4'b1100;
      watch(25);
      check("restart_rises", w_rise, 1);
      check("restart_blank_len", w_blank, 5 + BLANK);
      check("restart_view", view, 3);
      button = 4'b0000;

      // Idle behaviour from view 3
      clear_watch();
`ifdef VIEW_AUTO_CYCLE_EN
      watch(40);
      check("auto_rises", w_rise, 1);
      check("auto_blank_len", w_blank, BLANK);
      check("auto_view", view, 0);
`else
      watch(100);
      check("idle_rises", w_rise, 0);
      check("idle_view", view, 3);
`endif

      // Reset mid-blank abandons pending; a held button presses again
      do_reset(2);
      clear_watch();
      button = 4'b0100;
      watch(10);
      check("midrst_blanking", blanking, 1);
      do_reset(2);
      check("midrst_pending", debug_pending, 0);
      clear_watch();
      watch(20);
      check("midrst_rises", w_rise, 1);
      check("midrst_view", view, 2);
      button = 4'b0000;

      // Randomized run against the model
      for (int b = 0; b < 4; b++) btn_timer[b] = $urandom_range(1, 15);
      rst_left = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) reset = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            reset    = 1'b0;
            rst_left = $urandom_range(1, 3);
         end
         for (int b = 0; b < 4; b++) begin
            if (btn_timer[b] == 0) begin
               button[b]    = ~button[b];
               btn_timer[b] = $urandom_range(1, 15);
            end else begin
               btn_timer[b]--;
            end
         end
         sig_valid = ($urandom_range(0, 3) != 0);
         sig_0 = DW'($urandom);
         sig_1 = DW'($urandom);
         sig_2 = DW'($urandom);
         sig_3 = DW'($urandom);
      end
      reset = 1'b1;
      button = 4'b0000;
      repeat (40) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/view_sequencer.md
VIEW_SEQUENCER -- requirements
Module: view_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the number of consecutive stable clock cycles needed to accept a button level.
REQ-002 Parameter BLANK_CYCLES, default 256, SHALL set the number of clock cycles the output is blanked on a view change.
REQ-003 Parameter DATA_W, default 12, SHALL set the signal sample width.
REQ-004 Parameter AUTO_PERIOD, default 50000000, SHALL set the idle cycles before an auto-advance; it is used only under VIEW_AUTO_CYCLE_EN.
REQ-005 Port clock  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-006 Port reset  in  1  SHALL be the synchronous, active-low reset.
REQ-007 Port button  in  4  SHALL carry the raw asynchronous push-buttons, active-high; bit n requests view n.
REQ-008 Ports sig_0..sig_3  in  DATA_W each  SHALL carry the signed samples: upsampled, shaped, filtered and modulator streams.
REQ-009 Port sig_valid  in  1  SHALL qualify all four sig_n inputs together.
REQ-010 Port out_data  out  DATA_W  SHALL carry the selected (or blanked) sample.
REQ-011 Port out_valid  out  1  SHALL qualify out_data.
REQ-012 Port view  out  2  SHALL carry the currently displayed view code.
REQ-013 Port blanking  out  1  SHALL be high while in the BLANK state.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-015 The debouncer SHALL accept a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-016 A 0->1 transition of a debounced level SHALL produce exactly one press pulse lasting one cycle; a held button SHALL produce no further pulses.
REQ-017 Simultaneous press pulses SHALL be resolved by fixed priority, lowest index winning.
REQ-018 A press for the view already shown (state SHOW) SHALL be ignored.
REQ-019 The FSM SHALL have two states, SHOW and BLANK.
REQ-020 In SHOW, an accepted press to view v SHALL, on the next edge: latch pending=v, load the blank counter with BLANK_CYCLES-1, and enter BLANK.
REQ-021 In BLANK, a press SHALL overwrite pending and reload the counter, latest press winning. A press equal to the current view SHALL also be accepted.
REQ-022 In BLANK, when the counter reaches 0, the next edge SHALL set view=pending and enter SHOW; total blanking is exactly BLANK_CYCLES cycles with no intervening press.
REQ-023 The output register SHALL have 1-cycle latency.
REQ-024 Output timing SHALL be: out_valid(t+1)=sig_valid(t); out_data(t+1)=sig_view(t) in SHOW and 0 in BLANK; out_data SHALL hold when sig_valid=0.
REQ-025 view SHALL change only on the BLANK->SHOW edge; blanking SHALL be a registered state decode.

Reset
REQ-026 With reset low at a clock edge, the block SHALL drive view=0, out_data=0, out_valid=0 and blanking=0, with FSM=SHOW, counters=0, and synchronizer and debounced levels=0.
REQ-027 Reset asserted mid-BLANK SHALL abandon pending; after release, a still-held button SHALL be treated as a new press once debounced.

Configuration
REQ-028 With macro VIEW_AUTO_CYCLE_EN defined, an idle counter SHALL count cycles in SHOW and clear on any press pulse or in BLANK. On reaching AUTO_PERIOD-1 it SHALL enter BLANK with pending=view+1 (3 wraps to 0).
REQ-029 Without VIEW_AUTO_CYCLE_EN, no idle counter SHALL exist and view SHALL change only on presses.

Structure
REQ-030 Package view_pkg SHALL hold the view codes (VIEW_UPSAMPLED=0, VIEW_SHAPED=1, VIEW_FILTERED=2, VIEW_MODULATOR=3), the FSM state encoding and the default parameter constants.
REQ-031 Sub-module button_debounce (synchronizer, counter, press pulse) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, BLANK_CYCLES=8, AUTO_PERIOD=32)
REQ-032 Scenario: reset low 3 cycles, sig_valid=1 and sig_0=0x123 -> one cycle after release out_data=0x123, view=0, blanking=0.
REQ-033 Scenario: button[2] held 20 cycles -> exactly 1 pulse; blanking high 8 cycles with out_data=0; then view=2 and out_data follows sig_2.
REQ-034 Scenario: button[1] bounces with 2-cycle glitches, then holds -> no pulse until 4 stable cycles; exactly one view change to 1.
REQ-035 Scenario: button[3] and button[1] rise on the same cycle -> pending=1 and view=1.
REQ-036 Scenario: press 2, then press 3 at BLANK cycle 5 -> blanking lasts 5+8=13 cycles and view=3.
REQ-037 Scenario: with VIEW_AUTO_CYCLE_EN, 32 idle cycles in view 3 -> BLANK then view=0; without the macro, 100 idle cycles leave view unchanged.
